// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory requester and its byte-lane helper.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam logic [1:0] LANE_B0 = 2'd0;
  localparam logic [1:0] LANE_B1 = 2'd1;
  localparam logic [1:0] LANE_B2 = 2'd2;
  localparam logic [1:0] LANE_B3 = 2'd3;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  function automatic logic is_misaligned(input logic byte_acc, input logic [1:0] offset);
    return !byte_acc && ((offset & WORD_ALIGN_MASK) != 2'b00);
  endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Little-endian byte lane helper: extracts one lane with sign/zero extension and
// merges a new byte into a word at the same lane.
module byte_lane_unit
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic        sign_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] ext_o,
  output logic [31:0] merged_o
);

  logic [7:0] lane;

  always_comb begin
    lane     = 8'h00;
    merged_o = word_i;
    case (offset_i)
      LANE_B0: begin lane = word_i[7:0];   merged_o[7:0]   = byte_i; end
      LANE_B1: begin lane = word_i[15:8];  merged_o[15:8]  = byte_i; end
      LANE_B2: begin lane = word_i[23:16]; merged_o[23:16] = byte_i; end
      LANE_B3: begin lane = word_i[31:24]; merged_o[31:24] = byte_i; end
      default: begin lane = 8'h00; end
    endcase
    ext_o = {{24{sign_i & lane[7]}}, lane};
  end

endmodule

// File: rtl/mem_access_unit.sv
// Requester side of the data-memory port: word-only memory traffic, byte loads by
// lane extraction, byte stores by read-modify-write, misaligned words rejected.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned READ_WAIT = 1,
  parameter int unsigned ADDR_W    = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_error,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_byte_ops,
  input  logic [31:0]       mem_read_data
);

  localparam logic [3:0] RD_CNT = 4'(READ_WAIT);

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              write_q;
  logic              byte_q;
  logic              signed_q;
  logic [1:0]        off_q;
  logic [7:0]        wbyte_q;
  logic              resp_valid_q;
  logic [31:0]       resp_rdata_q;
  logic              resp_error_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              mem_read_q;
  logic              mem_write_q;

  logic [31:0]       ext_d;
  logic [31:0]       merged_d;
  logic              misaligned_d;

  // Lane logic works on the live read data so the last RD edge can capture the result.
  byte_lane_unit u_lane (
    .word_i   (mem_read_data),
    .offset_i (off_q),
    .sign_i   (signed_q),
    .byte_i   (wbyte_q),
    .ext_o    (ext_d),
    .merged_o (merged_d)
  );

  assign misaligned_d = is_misaligned(req_byte, req_addr[1:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      byte_q       <= 1'b0;
      signed_q     <= 1'b0;
      off_q        <= '0;
      wbyte_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            write_q    <= req_write;
            byte_q     <= req_byte;
            signed_q   <= req_signed;
            off_q      <= req_addr[1:0];
            wbyte_q    <= req_wdata[7:0];
            mem_addr_q <= {req_addr[ADDR_W-1:2], 2'b00};
            if (misaligned_d) begin
              resp_valid_q <= 1'b1;
              resp_error_q <= 1'b1;
              resp_rdata_q <= '0;
              state_q      <= ST_RESP;
            end else if (req_write && !req_byte) begin
              mem_wdata_q <= req_wdata;
              mem_write_q <= 1'b1;
              state_q     <= ST_WR;
            end else begin
              cnt_q      <= RD_CNT;
              mem_read_q <= 1'b1;
              state_q    <= ST_RD;
            end
          end
        end
        ST_RD: begin
          if (cnt_q == 4'd1) begin
            mem_read_q <= 1'b0;
            if (write_q) begin
              mem_wdata_q <= merged_d;
              mem_write_q <= 1'b1;
              state_q     <= ST_WR;
            end else begin
              resp_rdata_q <= byte_q ? ext_d : mem_read_data;
              resp_error_q <= 1'b0;
              resp_valid_q <= 1'b1;
              state_q      <= ST_RESP;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_WR: begin
          mem_write_q  <= 1'b0;
          resp_error_q <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= ST_RESP;
        end
        ST_RESP: begin
          resp_valid_q <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready      = (state_q == ST_IDLE);
  assign resp_valid     = resp_valid_q;
  assign resp_rdata     = resp_rdata_q;
  assign resp_error     = resp_error_q;
  assign mem_address    = mem_addr_q;
  assign mem_write_data = mem_wdata_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_byte_ops   = 1'b0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a small word memory behind it.
module tb_mem_access_unit;
  localparam int RW = 3;
  localparam int AW = 18;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_write, req_byte, req_signed;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid, resp_error;
  logic [31:0]   resp_rdata;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_write_data, mem_read_data;
  logic          mem_read, mem_write, mem_byte_ops;

  mem_access_unit #(.READ_WAIT(RW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_byte(req_byte), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_ops(mem_byte_ops), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  logic [31:0] tb_mem  [0:15];
  logic [31:0] ref_mem [0:15];
  assign mem_read_data = tb_mem[mem_address[5:2]];
  always @(posedge clk) if (mem_write) tb_mem[mem_address[5:2]] <= mem_write_data;

  typedef struct {
    logic        is_load;
    logic        mis;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          rd;
    int          wr;
    logic [31:0] wdata;
    logic [31:0] addr;
  } exp_t;
  exp_t sb_q[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  int   cyc = 0, acc_cyc = 0, rd_cnt = 0, wr_cnt = 0, wr_total = 0;
  int   excl_viol = 0, rdy_viol = 0;
  logic busy = 1'b0;
  logic [31:0] wcap;
  int   acc_log[$], resp_log[$];

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (mem_read && mem_write) excl_viol++;
    if (mem_write) wr_total++;
    if (reset) begin
      busy = 1'b0;
    end else if (busy) begin
      if (req_ready) rdy_viol++;
      if (mem_read) rd_cnt++;
      if (mem_write) begin wr_cnt++; wcap = mem_write_data; end
      if (resp_valid) begin
        if (sb_q.size() == 0) begin
          chk("sb_empty", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("latency", cyc - acc_cyc, e.lat);
          chk("resp_error", 32'(resp_error), 32'(e.err));
          if (e.is_load) chk("resp_rdata", resp_rdata, e.rdata);
          chk("rd_cycles", rd_cnt, e.rd);
          chk("wr_cycles", wr_cnt, e.wr);
          if (e.wr > 0) chk("wdata", wcap, e.wdata);
          if (!e.mis) chk("mem_address", 32'(mem_address), e.addr);
        end
        resp_log.push_back(cyc);
        busy = 1'b0;
      end
    end else if (req_valid && req_ready) begin
      busy = 1'b1; acc_cyc = cyc; rd_cnt = 0; wr_cnt = 0;
      acc_log.push_back(cyc);
    end
  end

  // Caller is just after a posedge; returns just after the accept edge.
  task automatic issue(input logic wr, input logic by, input logic sg, input logic [AW-1:0] a,
                       input logic [31:0] wd, input logic push, input logic keep_valid);
    exp_t e;
    int w, sh;
    logic [7:0]  b;
    logic [31:0] old, tmp;
    logic ok;
    w = int'(a[5:2]); sh = 8 * int'(a[1:0]); old = ref_mem[w];
    e.mis = !by && (a[1:0] != 2'b00);
    e.addr = 32'({a[AW-1:2], 2'b00});
    e.is_load = !wr || e.mis;
    e.err = e.mis; e.rdata = 32'h0; e.rd = 0; e.wr = 0; e.wdata = 32'h0;
    if (e.mis) begin
      e.lat = 1;
    end else if (!wr) begin
      e.lat = RW + 1; e.rd = RW;
      tmp = old >> sh; b = tmp[7:0];
      e.rdata = !by ? old : (sg ? {{24{b[7]}}, b} : {24'h0, b});
    end else if (!by) begin
      e.lat = 2; e.wr = 1; e.wdata = wd;
    end else begin
      e.lat = RW + 2; e.rd = RW; e.wr = 1;
      e.wdata = (old & ~(32'hFF << sh)) | ({24'h0, wd[7:0]} << sh);
    end
    if (push) begin
      sb_q.push_back(e);
      if (wr && !e.mis) ref_mem[w] = e.wdata;
    end
    req_write = wr; req_byte = by; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
    end
    if (!ok) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    if (!keep_valid) req_valid = 1'b0;
  endtask

  task automatic drain();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge clk); #1;
      if (sb_q.size() == 0 && !busy) ok = 1'b1;
    end
    if (!ok) chk("drain_timeout", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"},  32'(req_ready), 32'd1);
    chk({tag, "_rvalid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_rdata"},  resp_rdata, 32'd0);
    chk({tag, "_rerr"},   32'(resp_error), 32'd0);
    chk({tag, "_mrd"},    32'(mem_read), 32'd0);
    chk({tag, "_mwr"},    32'(mem_write), 32'd0);
    chk({tag, "_maddr"},  32'(mem_address), 32'd0);
    chk({tag, "_mwdata"}, mem_write_data, 32'd0);
    chk({tag, "_bops"},   32'(mem_byte_ops), 32'd0);
  endtask

  initial begin
    int n_acc, n_resp, wr_before;
    for (int i = 0; i < 16; i++) begin tb_mem[i] = 32'h0; ref_mem[i] = 32'h0; end
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0;
    req_signed = 1'b0; req_addr = '0; req_wdata = 32'h0;
    #12;
    chk_reset_outputs("rst0");
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); #1;

    issue(1, 0, 0, 18'h00008, 32'h695A955A, 1, 0);
    issue(0, 0, 0, 18'h00008, 32'h0, 1, 0);

    issue(1, 0, 0, 18'h00004, 32'h80FF7F01, 1, 0);
    issue(0, 1, 1, 18'h00006, 32'h0, 1, 0);
    issue(0, 1, 1, 18'h00005, 32'h0, 1, 0);
    issue(0, 1, 0, 18'h00007, 32'h0, 1, 0);
    issue(0, 1, 1, 18'h00007, 32'h0, 1, 0);
    issue(0, 1, 0, 18'h00004, 32'h0, 1, 0);

    issue(1, 0, 0, 18'h0000C, 32'h11223344, 1, 0);
    issue(1, 1, 0, 18'h0000D, 32'hFFFFFFAA, 1, 0);
    issue(0, 0, 0, 18'h0000C, 32'h0, 1, 0);
    issue(1, 1, 0, 18'h0000F, 32'h0000005E, 1, 0);
    issue(0, 0, 0, 18'h0000C, 32'h0, 1, 0);

    issue(0, 0, 0, 18'h00009, 32'h0, 1, 0);
    issue(1, 0, 0, 18'h0000A, 32'hDEADBEEF, 1, 0);
    issue(0, 0, 0, 18'h00008, 32'h0, 1, 0);
    drain();

    n_acc = acc_log.size(); n_resp = resp_log.size();
    issue(1, 0, 0, 18'h00014, 32'h12345678, 1, 1);
    issue(0, 0, 0, 18'h00014, 32'h0, 1, 0);
    drain();
    if (acc_log.size() >= n_acc + 2 && resp_log.size() >= n_resp + 1)
      chk("b2b_gap", acc_log[n_acc + 1] - resp_log[n_resp], 32'd1);
    else
      chk("b2b_log", 32'(acc_log.size() - n_acc), 32'd2);

    issue(1, 0, 0, 18'h00010, 32'hCAFEBABE, 1, 0);
    drain();
    wr_before = wr_total;
    issue(1, 1, 0, 18'h00011, 32'h00000055, 0, 0);
    chk("rmw_in_rd", 32'(mem_read), 32'd1);
    reset = 1'b1;
    #1;
    chk_reset_outputs("rst_mid");
    repeat (3) @(posedge clk);
    #1; reset = 1'b0;
    repeat (RW + 3) @(posedge clk);
    #1;
    chk("rst_no_write", wr_total - wr_before, 32'd0);
    chk("rst_mem_kept", tb_mem[4], 32'hCAFEBABE);
    chk("rst_ready", 32'(req_ready), 32'd1);
    issue(0, 0, 0, 18'h00010, 32'h0, 1, 0);
    drain();

    chk("excl_rd_wr", excl_viol, 32'd0);
    chk("ready_while_busy", rdy_viol, 32'd0);
    chk("sb_left", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
